mux_sel_pipe: RTL and testbench
===============================

Name: mux_sel_pipe

Overview:
Parametrised N-way, WIDTH-bit select mux for the RISC-V datapath (operand/writeback select), generalising the 2:1 32-bit mux.
The selected word is registered into a 2-entry skid buffer with valid/ready handshakes on both sides, so select paths can be retimed across pipeline stages without losing data under stall.
It also provides an out-of-range select flag and a synchronous flush for pipeline kill.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 4, number of input channels (≥2)
SEL_W, 2, select width; must satisfy 2**SEL_W ≥ NUM_IN

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  packed inputs; channel k = in_data[k*WIDTH +: WIDTH]
sel  input  SEL_W  channel select, sampled with in_data
in_valid  input  1  upstream has a word to transfer
in_ready  output  1  block can accept a word this cycle
flush  input  1  synchronous kill of all buffered entries
out_data  output  WIDTH  selected word at buffer head
out_sel_err  output  1  head entry was captured with sel ≥ NUM_IN
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head this cycle
count  output  2  buffer occupancy, 0..2

Behaviour:
- Reset (rst_n low, asynchronous): count=0, out_valid=0, out_data=0, out_sel_err=0, both buffer entries cleared to 0. in_ready=1 while in reset.
- in_ready = (count != 2). It is a function of registered state only; there is no combinational path from out_ready.
- Push: in_valid & in_ready & !flush.
  - Captured entry is {in_data[sel*WIDTH +: WIDTH], 0}, or {0, 1} when sel ≥ NUM_IN.
  - Out-of-range select still transfers a word (zero data, err flag set).
- Pop: out_valid & out_ready & !flush.
- out_valid = (count != 0). out_data and out_sel_err always show the head entry.
- Latency: a word pushed in cycle T appears at the output in cycle T+1 if the buffer was empty. With one older entry present, it appears after that entry pops.
- Ordering is strict FIFO; no reordering.
- Occupancy transitions, next count:
  - push only: +1
  - pop only: −1
  - push & pop at count 1: stays 1, and the new word becomes head next cycle
  - push & pop at count 0: impossible (out_valid=0), so this is a push only
- count=2: in_ready=0, so there is no push. A pop drops count to 1 and promotes entry 1 to head.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sel_err must not change.
- Flush (synchronous, highest priority): next cycle count=0 and out_valid=0. Any push or pop in the flush cycle is discarded and does not count as a transfer. Entry contents after flush are don't-care, but out_data must read 0 when count=0.
- Reset asserted mid-transfer: buffered words are lost, and no partial state survives.
- in_valid with in_ready=0: no capture. Upstream must hold in_data/sel stable; the block does not check this.
- NUM_IN not a power of two: the unused sel codes are the out-of-range case.

Test Plan:
1. Reset and basic path: hold rst_n=0 for 3 cycles -> count=0, out_valid=0, out_data=0, in_ready=1. Then NUM_IN=4, WIDTH=32, inputs ch0..3 = 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x33333333, out_sel_err=0; following cycle out_valid=0.
2. Backpressure fill: out_ready=0, push sel=0 then sel=3 -> count=2, in_ready=0. Third word (sel=1) is held off. Raise out_ready -> outputs 0x11111111 then 0x44444444 then 0x22222222 in consecutive cycles with no loss.
3. Simultaneous push/pop at count 1: stream 8 words with in_valid=out_ready=1 every cycle -> count stays 1 and output order equals input order. Hold out_data stable across any cycle with out_ready=0.
4. Out-of-range select: NUM_IN=3, SEL_W=2, sel=3 -> out_data=0, out_sel_err=1. The word still pops normally.
5. Flush priority: count=2, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0. No word is delivered and the new word is not captured.
6. Asynchronous reset mid-stream: drop rst_n between clock edges while count=2 -> count, out_valid and out_data go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mux_sel_pipe.sv
// N-way WIDTH-bit select mux feeding a 2-entry skid buffer with valid/ready on both sides.
// Out-of-range selects still transfer a zero word tagged with an error flag.
module mux_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } entry_t;

    entry_t     ent0_q, ent0_d;   // head
    entry_t     ent1_q, ent1_d;   // second (skid) slot
    entry_t     new_ent;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    // Any select code with no matching channel falls through as an error word.
    always_comb begin
        new_ent.data = '0;
        new_ent.err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                new_ent.data = in_data[k*WIDTH +: WIDTH];
                new_ent.err  = 1'b0;
            end
        end
    end

    assign in_ready    = (count_q != 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign out_data    = out_valid ? ent0_q.data : '0;
    assign out_sel_err = out_valid ? ent0_q.err  : 1'b0;
    assign count       = count_q;

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (flush) begin
            count_d = 2'd0;
            ent0_d  = '0;
            ent1_d  = '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        ent0_d  = new_ent;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_d = new_ent;
                    end else if (push) begin
                        ent1_d  = new_ent;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent0_d  = ent1_q;
                        count_d = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Table-driven bench for mux_sel_pipe: a 4-input instance for the main flows and
// a 3-input instance for the unused-select-code case.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] in_data;
    logic [1:0]   sel;
    logic         in_valid, in_ready, flush, out_sel_err, out_valid, out_ready;
    logic [31:0]  out_data;
    logic [1:0]   count;

    logic [1:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_out_sel_err, b_out_valid, b_out_ready;
    logic [31:0]  b_out_data;
    logic [1:0]   b_count;
    logic         b_flush;

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_sel_err(out_sel_err), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
        .out_data(b_out_data), .out_sel_err(b_out_sel_err), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .count(b_count)
    );

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic [1:0]  cnt;
        logic        ov;
        logic [31:0] data;
        logic        err;
        logic        irdy;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm,
                       input logic [1:0] a_cnt, input logic a_ov, input logic [31:0] a_d,
                       input logic a_err, input logic a_irdy,
                       input logic [1:0] e_cnt, input logic e_ov, input logic [31:0] e_d,
                       input logic e_err, input logic e_irdy);
        n_vec++;
        if (a_cnt !== e_cnt || a_ov !== e_ov || a_d !== e_d || a_err !== e_err || a_irdy !== e_irdy) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d ov=%b data=%h err=%b irdy=%b, want cnt=%0d ov=%b data=%h err=%b irdy=%b",
                     nm, a_cnt, a_ov, a_d, a_err, a_irdy, e_cnt, e_ov, e_d, e_err, e_irdy);
        end
    endtask

    task automatic chk_a(input string nm, input logic [1:0] e_cnt, input logic e_ov,
                         input logic [31:0] e_d, input logic e_err, input logic e_irdy);
        chk(nm, count, out_valid, out_data, out_sel_err, in_ready, e_cnt, e_ov, e_d, e_err, e_irdy);
    endtask

    task automatic chk_b(input string nm, input logic [1:0] e_cnt, input logic e_ov,
                         input logic [31:0] e_d, input logic e_err, input logic e_irdy);
        chk(nm, b_count, b_out_valid, b_out_data, b_out_sel_err, b_in_ready, e_cnt, e_ov, e_d, e_err, e_irdy);
    endtask

    task automatic drive_a(input logic iv, input logic [1:0] s, input logic ordy, input logic fl);
        in_valid = iv; sel = s; out_ready = ordy; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic drive_b(input logic iv, input logic [1:0] s, input logic ordy);
        b_in_valid = iv; b_sel = s; b_out_ready = ordy;
        @(posedge clk); #1;
    endtask

    initial begin
        //          iv    sel    ordy  fl     cnt    ov    data           err   irdy
        // basic path
        vt[0]  = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 32'h33333333, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        // backpressure fill then drain 11, 44, 22
        vt[2]  = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h11111111, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd2, 1'b1, 32'h11111111, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 1'b1, 32'h11111111, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h44444444, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22222222, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        // streaming at count 1, with a two-cycle stall
        vt[8]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h11111111, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22222222, 1'b0, 1'b1};
        vt[10] = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 32'h33333333, 1'b0, 1'b1};
        vt[11] = '{1'b1, 2'd3, 1'b1, 1'b0, 2'd1, 1'b1, 32'h44444444, 1'b0, 1'b1};
        vt[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h44444444, 1'b0, 1'b1};
        vt[13] = '{1'b0, 2'd2, 1'b0, 1'b0, 2'd1, 1'b1, 32'h44444444, 1'b0, 1'b1};
        vt[14] = '{1'b1, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h11111111, 1'b0, 1'b1};
        vt[15] = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22222222, 1'b0, 1'b1};
        vt[16] = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 32'h33333333, 1'b0, 1'b1};
        vt[17] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        // flush at count 2 with push and pop both offered
        vt[18] = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h11111111, 1'b0, 1'b1};
        vt[19] = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd2, 1'b1, 32'h11111111, 1'b0, 1'b0};
        vt[20] = '{1'b1, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vt[21] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        // flush at count 1 with a push offered
        vt[22] = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b1, 32'h44444444, 1'b0, 1'b1};
        vt[23] = '{1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};

        in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        rst_n = 1'b0;
        in_valid = 1'b0; sel = 2'd0; out_ready = 1'b0; flush = 1'b0;
        b_in_valid = 1'b0; b_sel = 2'd0; b_out_ready = 1'b0; b_flush = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_a("reset", 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_b("reset_b", 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive_a(vt[i].iv, vt[i].sel, vt[i].ordy, vt[i].fl);
            chk_a($sformatf("vec%0d", i), vt[i].cnt, vt[i].ov, vt[i].data, vt[i].err, vt[i].irdy);
        end

        // unused select code on the 3-input instance
        drive_b(1'b1, 2'd3, 1'b0);
        chk_b("oor_push", 2'd1, 1'b1, 32'h0, 1'b1, 1'b1);
        drive_b(1'b1, 2'd2, 1'b0);
        chk_b("oor_hold", 2'd2, 1'b1, 32'h0, 1'b1, 1'b0);
        drive_b(1'b0, 2'd0, 1'b1);
        chk_b("oor_pop", 2'd1, 1'b1, 32'h33333333, 1'b0, 1'b1);
        drive_b(1'b0, 2'd0, 1'b1);
        chk_b("oor_drain", 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);

        // asynchronous reset with a full buffer
        drive_a(1'b1, 2'd2, 1'b0, 1'b0);
        drive_a(1'b1, 2'd3, 1'b0, 1'b0);
        chk_a("prefill", 2'd2, 1'b1, 32'h33333333, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_a("rst_held", 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b1;
        drive_a(1'b0, 2'd0, 1'b1, 1'b0);
        chk_a("post_rst", 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive_a(1'b1, 2'd1, 1'b1, 1'b0);
        chk_a("post_rst_push", 2'd1, 1'b1, 32'h22222222, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
